// File: rtl/nmea_pkg.sv
// nmea_pkg: definitions shared by the NMEA checksum checker and the NMEA parser.
//   - ASCII framing characters of an NMEA 0183 sentence
//   - FSM state encoding of the checksum checker
//   - small character-class helper
package nmea_pkg;

    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BODY,
        ST_HEX_HI,
        ST_HEX_LO,
        ST_EOL
    } nmea_state_t;

    // CR or LF both terminate a sentence.
    function automatic logic is_eol(input logic [7:0] ch);
        return (ch == ASCII_CR) || (ch == ASCII_LF);
    endfunction

endpackage

// File: rtl/nmea_checksum_checker_if.sv
// nmea_checksum_checker_if: byte stream with a one-cycle valid strobe.
//   data  : 8-bit character
//   valid : strobe, data is meaningful this cycle
// Modports: master drives the stream, slave receives it.
interface nmea_checksum_checker_if;
    logic [7:0] data;
    logic       valid;

    modport master (output data, output valid);
    modport slave  (input  data, input  valid);
endinterface

// File: rtl/hex_nibble_decode.sv
// hex_nibble_decode: combinational ASCII hex digit decoder.
//   ch     in  8  ASCII character
//   nibble out 4  value of the digit (0 when not a hex digit)
//   is_hex out 1  ch is one of 0-9, A-F, a-f
module hex_nibble_decode (
    input  logic [7:0] ch,
    output logic [3:0] nibble,
    output logic       is_hex
);

    always_comb begin
        nibble = 4'd0;
        is_hex = 1'b0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            nibble = ch[3:0];
            is_hex = 1'b1;
        end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so adding 9 yields 10..15.
            nibble = ch[3:0] + 4'd9;
            is_hex = 1'b1;
        end
    end

endmodule

// File: rtl/nmea_checksum_checker.sv
// nmea_checksum_checker: verifies the XOR checksum of NMEA sentences in a
// received byte stream and forwards every byte with one cycle of latency.
//   clk_50MHz    in   system clock
//   reset        in   synchronous, active-high reset
//   rx           slave  incoming bytes (data/valid) from the UART
//   out          master forwarded bytes to the parser (1-cycle latency)
//   sof          out  pulse: '$' accepted, sentence started
//   checksum_ok  out  pulse: sentence verified
//   checksum_err out  pulse: sentence failed
//   calc_sum     out  running/final XOR of the body, held after the verdict
//   good_count   out  saturating count of ok sentences
//   bad_count    out  saturating count of failed sentences
module nmea_checksum_checker
    import nmea_pkg::*;
#(
    parameter int MAX_LEN    = 96,
    parameter int CNT_W      = 16,
    parameter bit REQUIRE_CS = 1'b1
) (
    input  logic                    clk_50MHz,
    input  logic                    reset,
    nmea_checksum_checker_if.slave  rx,
    nmea_checksum_checker_if.master out,
    output logic                    sof,
    output logic                    checksum_ok,
    output logic                    checksum_err,
    output logic [7:0]              calc_sum,
    output logic [CNT_W-1:0]        good_count,
    output logic [CNT_W-1:0]        bad_count
);

    localparam int               LEN_W     = $clog2(MAX_LEN + 2);
    localparam logic [LEN_W-1:0] LEN_LIMIT = LEN_W'(MAX_LEN);

    nmea_state_t      state;
    logic [LEN_W-1:0] len;
    logic [7:0]       cs_rx;      // checksum received after '*'

    logic [3:0]       nibble;
    logic             is_hex;

    logic             is_dollar;
    logic             is_star;
    logic             is_end;
    logic             hit_start;
    logic             hit_ok;
    logic             hit_err;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    hex_nibble_decode u_hex (
        .ch     (rx.data),
        .nibble (nibble),
        .is_hex (is_hex)
    );

    // Decode what the current byte means for the sentence in progress.
    // A '$' outside IDLE both fails the old sentence and starts a new one.
    always_comb begin
        is_dollar = (rx.data == ASCII_DOLLAR);
        is_star   = (rx.data == ASCII_STAR);
        is_end    = is_eol(rx.data);
        hit_start = 1'b0;
        hit_ok    = 1'b0;
        hit_err   = 1'b0;
        if (rx.valid) begin
            unique case (state)
                ST_IDLE: begin
                    hit_start = is_dollar;
                end
                ST_BODY: begin
                    if (is_star) begin
                        hit_start = 1'b0;
                    end else if (is_end) begin
                        hit_ok  = !REQUIRE_CS;
                        hit_err = REQUIRE_CS;
                    end else if (is_dollar) begin
                        hit_err   = 1'b1;
                        hit_start = 1'b1;
                    end else begin
                        // len counts characters already absorbed; this one overflows.
                        hit_err = (len == LEN_LIMIT);
                    end
                end
                ST_HEX_HI, ST_HEX_LO: begin
                    hit_err   = !is_hex;
                    hit_start = is_dollar;
                end
                ST_EOL: begin
                    if (is_end) begin
                        hit_ok  = (cs_rx == calc_sum);
                        hit_err = (cs_rx != calc_sum);
                    end else begin
                        hit_err   = 1'b1;
                        hit_start = is_dollar;
                    end
                end
                default: begin
                    hit_start = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state        <= ST_IDLE;
            len          <= '0;
            cs_rx        <= '0;
            calc_sum     <= '0;
            sof          <= 1'b0;
            checksum_ok  <= 1'b0;
            checksum_err <= 1'b0;
            good_count   <= '0;
            bad_count    <= '0;
            out.data     <= '0;
            out.valid    <= 1'b0;
        end else begin
            out.data     <= rx.data;
            out.valid    <= rx.valid;
            sof          <= hit_start;
            checksum_ok  <= hit_ok;
            checksum_err <= hit_err;
            if (hit_ok) begin
                good_count <= sat_inc(good_count);
            end
            if (hit_err) begin
                bad_count <= sat_inc(bad_count);
            end

            if (rx.valid) begin
                if (hit_start) begin
                    state    <= ST_BODY;
                    calc_sum <= '0;
                    len      <= '0;
                end else begin
                    unique case (state)
                        ST_IDLE: begin
                            state <= ST_IDLE;
                        end
                        ST_BODY: begin
                            if (is_star) begin
                                state <= ST_HEX_HI;
                            end else if (is_end) begin
                                state <= ST_IDLE;
                            end else begin
                                calc_sum <= calc_sum ^ rx.data;
                                len      <= len + LEN_W'(1);
                                if (len == LEN_LIMIT) begin
                                    state <= ST_IDLE;
                                end
                            end
                        end
                        ST_HEX_HI: begin
                            if (is_hex) begin
                                cs_rx[7:4] <= nibble;
                                state      <= ST_HEX_LO;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                        ST_HEX_LO: begin
                            if (is_hex) begin
                                cs_rx[3:0] <= nibble;
                                state      <= ST_EOL;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                        ST_EOL: begin
                            state <= ST_IDLE;
                        end
                        default: begin
                            state <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule
